// File: rtl/cache_pkg.sv
// Shared geometry helpers, operation encoding and LRU age constants for the
// set-associative cache array.
package cache_pkg;

  // Decoded operation after priority resolution of the controller strobes.
  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_READ   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_REFILL = 3'd3,
    OP_FLUSH  = 3'd4
  } op_e;

  function automatic int calc_sets(input int size_byte, input int block_bytes, input int ways);
    return size_byte / (block_bytes * ways);
  endfunction

  function automatic int calc_off_bits(input int block_bytes, input int width);
    return $clog2(block_bytes * 8 / width);
  endfunction

  function automatic int calc_idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_bits(input int addr_width, input int idx_bits, input int off_bits);
    return addr_width - idx_bits - off_bits;
  endfunction

  // Way-number width; a direct-mapped array still carries a 1-bit way field.
  function automatic int calc_way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Age a way holds after reset or flush: way 0 is MRU, way WAYS-1 is LRU.
  function automatic int age_reset(input int way);
    return way;
  endfunction

  // Strobe priority: flush > refill > write > read; losers are dropped.
  function automatic op_e op_select(input logic flush, input logic refill,
                                    input logic write, input logic read);
    if (flush)       return OP_FLUSH;
    else if (refill) return OP_REFILL;
    else if (write)  return OP_WRITE;
    else if (read)   return OP_READ;
    else             return OP_NONE;
  endfunction

endpackage

// File: rtl/cache_array_assoc_lru.sv
// True-LRU age tracking per set: victim choice, MRU promotion and
// per-set re-initialisation used by the flush walk.
module cache_lru_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int SETS     = 16,
  parameter int IDX_BITS = 4,
  parameter int WAY_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] i_set,
  input  logic [WAYS-1:0]     i_valid,
  input  logic                i_access,
  input  logic [WAY_BITS-1:0] i_access_way,
  input  logic                i_clear,
  input  logic [IDX_BITS-1:0] i_clear_set,
  output logic [WAY_BITS-1:0] o_victim_way
);

  if (WAYS == 1) begin : g_direct
    // Direct-mapped: the only way is always the target and no ages exist.
    assign o_victim_way = {WAY_BITS{1'b0}};
  end else begin : g_assoc
    logic [WAY_BITS-1:0] r_age [SETS][WAYS];
    logic [WAY_BITS-1:0] w_victim;
    logic                w_found;

    // Age update: reset/clear restore the initial permutation, an access
    // ages every younger way by one and makes the accessed way MRU.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            r_age[s][w] <= WAY_BITS'(age_reset(w));
          end
        end
      end else if (i_clear) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[i_clear_set][w] <= WAY_BITS'(age_reset(w));
        end
      end else if (i_access) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_BITS'(w) == i_access_way) begin
            r_age[i_set][w] <= {WAY_BITS{1'b0}};
          end else if (r_age[i_set][w] < r_age[i_set][i_access_way]) begin
            r_age[i_set][w] <= r_age[i_set][w] + WAY_BITS'(1);
          end else begin
            r_age[i_set][w] <= r_age[i_set][w];
          end
        end
      end else begin
        r_age <= r_age;
      end
    end

    // Victim: lowest-numbered invalid way first, otherwise the oldest way.
    always_comb begin
      w_victim = {WAY_BITS{1'b0}};
      w_found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (!i_valid[w] && !w_found) begin
          w_victim = WAY_BITS'(w);
          w_found  = 1'b1;
        end else begin
          w_found  = w_found;
        end
      end
      if (!w_found) begin
        for (int w = 0; w < WAYS; w++) begin
          if (r_age[i_set][w] == WAY_BITS'(WAYS - 1)) begin
            w_victim = WAY_BITS'(w);
          end else begin
            w_victim = w_victim;
          end
        end
      end else begin
        w_victim = w_victim;
      end
    end

    assign o_victim_way = w_victim;
  end

endmodule

// File: rtl/cache_array_assoc.sv
// N-way set-associative data/tag/valid array for the write-through cache.
// Combinational hit lookup, registered reads, byte-enabled write hits,
// block refills into the LRU victim, and a one-set-per-cycle flush walk.
module cache_array_assoc
  import cache_pkg::*;
#(
  parameter int  WIDTH       = 32,
  parameter int  SIZE_BYTE   = 512,
  parameter int  BLOCK_BYTES = 16,
  parameter int  WAYS        = 2,
  parameter int  ADDR_WIDTH  = 10,
  localparam int BLOCK_WORDS = BLOCK_BYTES * 8 / WIDTH,
  localparam int WAY_BITS    = calc_way_bits(WAYS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic                         op_read,
  input  logic                         op_write,
  input  logic                         op_refill,
  input  logic                         op_flush,
  input  logic [WIDTH-1:0]             write_data,
  input  logic [WIDTH/8-1:0]           byte_en,
  input  logic [BLOCK_WORDS*WIDTH-1:0] refill_block,
  output logic                         hit,
  output logic [WAY_BITS-1:0]          hit_way,
  output logic [WAY_BITS-1:0]          victim_way,
  output logic [WIDTH-1:0]             read_data,
  output logic                         read_valid,
  output logic                         busy
);

  localparam int SETS     = calc_sets(SIZE_BYTE, BLOCK_BYTES, WAYS);
  localparam int OFF_BITS = calc_off_bits(BLOCK_BYTES, WIDTH);
  localparam int IDX_BITS = calc_idx_bits(SETS);
  localparam int TAG_BITS = calc_tag_bits(ADDR_WIDTH, IDX_BITS, OFF_BITS);

  logic [WIDTH-1:0]    r_data  [SETS][WAYS][BLOCK_WORDS];
  logic [TAG_BITS-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]     r_valid [SETS];
  logic                r_busy;
  logic [IDX_BITS-1:0] r_flush_cnt;
  logic [WIDTH-1:0]    r_read_data;
  logic                r_read_valid;

  logic [TAG_BITS-1:0] w_tag;
  logic [IDX_BITS-1:0] w_idx;
  logic [OFF_BITS-1:0] w_off;
  logic                w_match;
  logic                w_hit;
  logic [WAY_BITS-1:0] w_hit_way;
  logic [WAY_BITS-1:0] w_victim;
  logic [WAY_BITS-1:0] w_refill_way;
  logic                w_lru_access;
  logic [WAY_BITS-1:0] w_lru_way;
  op_e                 w_op;

  assign w_tag = addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign w_idx = addr[OFF_BITS +: IDX_BITS];
  assign w_off = addr[OFF_BITS-1:0];

  // Tag compare across the ways of the addressed set; refills never create
  // duplicate tags, so the first match is the only match.
  always_comb begin
    w_match   = 1'b0;
    w_hit_way = {WAY_BITS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag) && !w_match) begin
        w_match   = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end else begin
        w_match   = w_match;
      end
    end
  end

  // A flush in progress hides the array and swallows every strobe.
  assign w_hit        = w_match & ~r_busy;
  assign w_op         = r_busy ? OP_NONE : op_select(op_flush, op_refill, op_write, op_read);
  assign w_refill_way = w_hit ? w_hit_way : w_victim;
  assign w_lru_access = (w_op == OP_REFILL) ||
                        (((w_op == OP_READ) || (w_op == OP_WRITE)) && w_hit);
  assign w_lru_way    = (w_op == OP_REFILL) ? w_refill_way : w_hit_way;

  cache_lru_ctrl #(
    .WAYS     (WAYS),
    .SETS     (SETS),
    .IDX_BITS (IDX_BITS),
    .WAY_BITS (WAY_BITS)
  ) u_lru (
    .clk          (clk),
    .reset        (reset),
    .i_set        (w_idx),
    .i_valid      (r_valid[w_idx]),
    .i_access     (w_lru_access),
    .i_access_way (w_lru_way),
    .i_clear      (r_busy),
    .i_clear_set  (r_flush_cnt),
    .o_victim_way (w_victim)
  );

  // Control state: valid bits, flush walk and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= {WAYS{1'b0}};
      end
      r_busy       <= 1'b0;
      r_flush_cnt  <= {IDX_BITS{1'b0}};
      r_read_data  <= {WIDTH{1'b0}};
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      if (r_busy) begin
        r_valid[r_flush_cnt] <= {WAYS{1'b0}};
        if (r_flush_cnt == IDX_BITS'(SETS - 1)) begin
          r_busy      <= 1'b0;
          r_flush_cnt <= {IDX_BITS{1'b0}};
        end else begin
          r_flush_cnt <= r_flush_cnt + IDX_BITS'(1);
        end
      end else begin
        case (w_op)
          OP_FLUSH: begin
            r_busy      <= 1'b1;
            r_flush_cnt <= {IDX_BITS{1'b0}};
          end
          OP_REFILL: begin
            r_valid[w_idx][w_refill_way] <= 1'b1;
          end
          OP_READ: begin
            if (w_hit) begin
              r_read_data  <= r_data[w_idx][w_hit_way][w_off];
              r_read_valid <= 1'b1;
            end else begin
              r_read_data  <= r_read_data;
            end
          end
          default: begin
            r_read_data <= r_read_data;
          end
        endcase
      end
    end
  end

  // Data and tag storage: byte-merged write hits and whole-block refills.
  always_ff @(posedge clk) begin
    case (w_op)
      OP_WRITE: begin
        if (w_hit) begin
          for (int b = 0; b < WIDTH / 8; b++) begin
            if (byte_en[b]) begin
              r_data[w_idx][w_hit_way][w_off][8*b +: 8] <= write_data[8*b +: 8];
            end
          end
        end
      end
      OP_REFILL: begin
        for (int k = 0; k < BLOCK_WORDS; k++) begin
          r_data[w_idx][w_refill_way][k] <= refill_block[k*WIDTH +: WIDTH];
        end
        r_tag[w_idx][w_refill_way] <= w_tag;
      end
      default: begin
        r_tag <= r_tag;
      end
    endcase
  end

  assign hit        = w_hit;
  assign hit_way    = w_hit ? w_hit_way : {WAY_BITS{1'b0}};
  assign victim_way = w_victim;
  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign busy       = r_busy;

endmodule

// File: doc/cache_array_assoc.md
Name: cache_array_assoc

Overview:
- Parametrised N-way set-associative successor to the direct-mapped cache data/tag array.
- Holds the data, tag, valid and true-LRU state for the write-through cache controller.
- Provides combinational hit lookup, registered word reads, byte-enabled write hits, victim-selected block refills, and a multi-cycle flush.
- The controller FSM drives it with single-cycle operation strobes.

Parameters:
- WIDTH, 32, word width in bits (multiple of 8).
- SIZE_BYTE, 512, total data capacity in bytes.
- BLOCK_BYTES, 16, block size in bytes; BLOCK_WORDS = BLOCK_BYTES*8/WIDTH.
- WAYS, 2, associativity; legal values 1, 2, 4.
- ADDR_WIDTH, 10, word-address width.
- Derived: SETS = SIZE_BYTE/(BLOCK_BYTES*WAYS); OFF_BITS = clog2(BLOCK_WORDS); IDX_BITS = clog2(SETS); TAG_BITS = ADDR_WIDTH-IDX_BITS-OFF_BITS.
- Defaults give 16 sets, 4 words/block, addr = {tag[3:0], index[3:0], offset[1:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- addr  in  ADDR_WIDTH  word address {tag, index, offset}
- op_read  in  1  read-word strobe
- op_write  in  1  write-word strobe (write hit)
- op_refill  in  1  block-refill strobe (read miss)
- op_flush  in  1  invalidate-all strobe
- write_data  in  WIDTH  word to write
- byte_en  in  WIDTH/8  byte enables for op_write
- refill_block  in  BLOCK_WORDS*WIDTH  block data; word 0 in LSBs
- hit  out  1  combinational: addr tag valid in some way of its set
- hit_way  out  clog2(WAYS) (min 1)  way that hits; 0 when no hit
- victim_way  out  clog2(WAYS) (min 1)  combinational refill target for addr's set
- read_data  out  WIDTH  registered read word
- read_valid  out  1  one-cycle pulse: read_data updated
- busy  out  1  flush in progress

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset:
  - All valid bits clear.
  - Per-set LRU ages: age[w] = w (0 = MRU, WAYS-1 = LRU).
  - read_data = 0, read_valid = 0, busy = 0.
  - Data and tag storage are not reset; the bench must not check them.
- Operation priority when several strobes are high: flush > refill > write > read. Losing strobes are dropped, not queued.
- While busy = 1:
  - All strobes are ignored.
  - hit = 0.
  - read_valid = 0.
- Read:
  - Hit: read_data <= the addressed word of hit_way at the next edge; read_valid = 1 for exactly that cycle; hit_way becomes MRU.
  - Miss: read_data holds; read_valid = 0; LRU unchanged.
- Write:
  - Hit: bytes with byte_en = 1 take write_data; other bytes keep their value. hit_way becomes MRU.
  - Miss: no state change (no-allocate; memory write handled by controller).
- Refill, target way selection:
  - If addr already hits, target = hit_way (no duplicate tags).
  - Otherwise, the lowest-numbered invalid way.
  - Otherwise, the way with age WAYS-1.
- Refill, update: the target gets refill_block, the tag, and valid = 1; target becomes MRU. Takes effect at the next edge; hit for the same addr is 1 from the following cycle.
- LRU update on access to way w with age a:
  - Every way in the set with age < a increments.
  - age[w] = 0.
  - Ages stay a permutation of 0..WAYS-1.
- Flush:
  - busy = 1 from the cycle after the strobe, for exactly SETS cycles.
  - An internal set counter walks 0..SETS-1, clearing valid bits and restoring reset ages for one set per cycle.
  - busy = 0 on the cycle after set SETS-1 is cleared; the counter then returns to 0.
- Reset mid-flush aborts the flush: busy = 0 and every set is cleared immediately.
- read_valid never asserts in the same cycle as a write, refill or flush.
- WAYS = 1 degenerates to direct-mapped: hit_way = victim_way = 0 and there is no LRU state.

Decomposition:
- Package cache_pkg holds:
  - derivation functions for SETS, OFF_BITS, IDX_BITS, TAG_BITS;
  - the operation-priority encoding (OP_NONE, OP_READ, OP_WRITE, OP_REFILL, OP_FLUSH);
  - the age-reset constant function.
- Sub-module cache_lru_ctrl holds the per-set age arrays. Responsibilities:
  - victim selection (invalid-first, then oldest);
  - MRU update;
  - flush/reset re-initialisation.
  - Interface: set index, valid vector, access strobe + way, clear strobe + set.
- Top level holds the data/tag/valid arrays, the flush counter and the read register.

Test Plan:
- After reset, op_read addr 0x000 -> hit = 0, read_valid stays 0, read_data = 0.
- op_refill addr 0x014 (tag 0, set 5) with words 0x00000000/0x11111111/0x22222222/0x33333333, then op_read 0x016 -> hit = 1, hit_way = 0, next cycle read_data = 0x22222222 with a one-cycle read_valid.
- op_write addr 0x015, write_data 0xAAAABBBB, byte_en 4'b0011, then op_read 0x015 -> read_data = 0x1111BBBB.
- LRU, set 5:
  - refill 0x054 (tag 1) lands in way 1;
  - read 0x014 (way 0 becomes MRU) -> victim_way = 1;
  - refill 0x094 (tag 2) replaces way 1;
  - read 0x054 misses; read 0x014 hits.
- op_flush with sets populated -> busy = 1 for 16 cycles, an op_refill issued mid-flush is ignored, afterwards read 0x014 misses and victim_way = 0.
- op_refill and op_read high together on 0x014 -> refill performed, read_valid = 0; next-cycle op_read hits.
